// File: rtl/hyperbus_pkg.sv
// HyperBus transaction splitter shared definitions.
// Holds the splitter FSM state type and the PHY-facing default widths.
package hyperbus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Defaults shared with the PHY transaction port.
    localparam int unsigned HB_BURST_WIDTH = 12;
    localparam int unsigned HB_NR_CS       = 2;

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// Combinational chunk size: min(remaining, MAX_BURST, words left in row).
// Ports: remaining (words left), row_offset (word offset in row), chunk.
module hyperbus_chunk_calc import hyperbus_pkg::*; #(
    parameter int unsigned BURST_WIDTH   = HB_BURST_WIDTH,
    parameter int unsigned MAX_BURST     = 256,
    parameter int unsigned BOUNDARY_LOG2 = 9
) (
    input  logic [15:0]              remaining,
    input  logic [BOUNDARY_LOG2-1:0] row_offset,
    output logic [BURST_WIDTH-1:0]   chunk
);

    // Wide enough for both a 16-bit length and a full row size.
    localparam int unsigned CW =
        (BOUNDARY_LOG2 + 1 > 17) ? BOUNDARY_LOG2 + 1 : 17;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] room_w;
    logic [CW-1:0] min_a;
    logic [CW-1:0] min_b;

    always_comb begin
        rem_w  = CW'(remaining);
        max_w  = CW'(MAX_BURST);
        room_w = (CW'(1) << BOUNDARY_LOG2) - CW'(row_offset);
        min_a  = (rem_w < max_w) ? rem_w : max_w;
        min_b  = (min_a < room_w) ? min_a : room_w;
        // min_b <= MAX_BURST, which fits BURST_WIDTH.
        chunk  = BURST_WIDTH'(min_b);
    end

endmodule

// File: rtl/hyperbus_trans_splitter.sv
// Splits word-length requests into PHY transactions bounded by burst and row.
// Ports: clk_i, rst_ni, req_* (request in), trans_* (PHY out), busy_o, err_o.
module hyperbus_trans_splitter import hyperbus_pkg::*; #(
    parameter int unsigned BURST_WIDTH   = HB_BURST_WIDTH,
    parameter int unsigned NR_CS         = HB_NR_CS,
    parameter int unsigned MAX_BURST     = 256,
    parameter int unsigned BOUNDARY_LOG2 = 9,
    parameter int unsigned CS_ADDR_LSB   = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic [15:0]            req_len_i,
    input  logic                   req_write_i,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   busy_o,
    output logic                   err_o
);

    // Word address inside one device; its carry out is dropped so
    // running past the device end wraps to word 0 of the same device.
    localparam int unsigned AW  = CS_ADDR_LSB - 1;
    localparam int unsigned CSW = (NR_CS > 1) ? $clog2(NR_CS) : 1;

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [15:0]            rem_q, rem_d;
    logic [15:0]            rem_next;
    logic [CSW-1:0]         cs_q, cs_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [BURST_WIDTH-1:0] chunk;
    logic                   unused_addr;

    // Only the chip-select and in-device bits are used.
    assign unused_addr = ^req_addr_i;

    hyperbus_chunk_calc #(
        .BURST_WIDTH  (BURST_WIDTH),
        .MAX_BURST    (MAX_BURST),
        .BOUNDARY_LOG2(BOUNDARY_LOG2)
    ) u_chunk (
        .remaining (rem_q),
        .row_offset(addr_q[BOUNDARY_LOG2-1:0]),
        .chunk     (chunk)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        cs_d     = cs_q;
        write_d  = write_q;
        err_d    = 1'b0;
        // Cannot underflow: chunk never exceeds rem_q.
        rem_next = rem_q - 16'(chunk);
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i[CS_ADDR_LSB-1:1];
                    rem_d   = req_len_i;
                    cs_d    = req_addr_i[CS_ADDR_LSB +: CSW];
                    write_d = req_write_i;
                    if (req_len_i == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (trans_ready_i) begin
                    addr_d = addr_q + AW'(chunk);
                    rem_d  = rem_next;
                    if (rem_next == 16'd0) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cs_q    <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cs_q    <= cs_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Transaction fields come straight from registers, so they hold
    // still for as long as the PHY stalls. They read zero when idle.
    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign trans_valid_o   = (state_q == ISSUE);
    assign trans_address_o = trans_valid_o ? 32'(addr_q) : '0;
    assign trans_cs_o      = trans_valid_o ? (NR_CS'(1) << cs_q) : '0;
    assign trans_write_o   = trans_valid_o & write_q;
    assign trans_burst_o   = trans_valid_o ? chunk : '0;
    assign err_o           = err_q;

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// Testbench for hyperbus_trans_splitter: directed table, corner sequences,
// and randomized requests against an arithmetic splitting model.
module tb_hyperbus_trans_splitter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [15:0] req_len_i = '0;
    logic        req_write_i = 1'b0;
    logic        trans_valid_o;
    logic        trans_ready_i = 1'b0;
    logic [31:0] trans_address_o;
    logic [1:0]  trans_cs_o;
    logic        trans_write_o;
    logic [11:0] trans_burst_o;
    logic        busy_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    hyperbus_trans_splitter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_len_i      (req_len_i),
        .req_write_i    (req_write_i),
        .trans_valid_o  (trans_valid_o),
        .trans_ready_i  (trans_ready_i),
        .trans_address_o(trans_address_o),
        .trans_cs_o     (trans_cs_o),
        .trans_write_o  (trans_write_o),
        .trans_burst_o  (trans_burst_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [11:0] b;
        logic [1:0]  cs;
        logic        w;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic        wr;
        int          hold;
        int          n;
        logic [31:0] a0, a1, a2;
        logic [11:0] b0, b1, b2;
        logic [1:0]  cs;
    } vec_t;

    txn_t exp_q[$];
    txn_t got_q[$];
    vec_t vecs[5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: split purely by arithmetic on word addresses.
    function automatic void build_model(logic [31:0] addr, int len,
                                        logic wr);
        int a;
        int rem;
        int c;
        exp_q.delete();
        a   = int'((addr >> 1) & 32'h003F_FFFF);
        rem = len;
        while (rem > 0) begin
            c = rem;
            if (c > 256) c = 256;
            if (c > 512 - (a % 512)) c = 512 - (a % 512);
            exp_q.push_back('{a: 32'(a), b: 12'(c),
                              cs: (addr[23] ? 2'b10 : 2'b01), w: wr});
            a   = (a + c) % (1 << 22);
            rem = rem - c;
        end
    endfunction

    task automatic cmp_model(string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_addr"}, got_q[i].a, exp_q[i].a);
            chk({tag, "_burst"}, 32'(got_q[i].b), 32'(exp_q[i].b));
            chk({tag, "_cs"}, 32'(got_q[i].cs), 32'(exp_q[i].cs));
            chk({tag, "_write"}, 32'(got_q[i].w), 32'(exp_q[i].w));
        end
    endtask

    // Called at posedge+1 with the DUT idle. Holds trans_ready_i low
    // for 'hold' cycles, then stalls randomly with 'stall_pct'.
    task automatic run_req(logic [31:0] addr, logic [15:0] len, logic wr,
                           int hold, int stall_pct);
        txn_t held;
        bit   stalled;
        int   cyc;
        int   nstall;
        got_q.delete();
        req_addr_i    = addr;
        req_len_i     = len;
        req_write_i   = wr;
        req_valid_i   = 1'b1;
        trans_ready_i = 1'b0;
        chk("req_ready_before", 32'(req_ready_o), 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("valid_latency", 32'(trans_valid_o), 1);
        stalled = 0;
        cyc     = 0;
        nstall  = 0;
        while (trans_valid_o && cyc < 3000) begin
            if (stalled) begin
                chk("stall_addr", trans_address_o, held.a);
                chk("stall_burst", 32'(trans_burst_o), 32'(held.b));
                chk("stall_cs", 32'(trans_cs_o), 32'(held.cs));
                chk("stall_write", 32'(trans_write_o), 32'(held.w));
            end
            held = '{a: trans_address_o, b: trans_burst_o,
                     cs: trans_cs_o, w: trans_write_o};
            if (nstall < hold) trans_ready_i = 1'b0;
            else trans_ready_i = ($urandom_range(0, 99) >= stall_pct);
            if (trans_ready_i) got_q.push_back(held);
            else nstall++;
            stalled = !trans_ready_i;
            @(posedge clk_i); #1;
            cyc++;
        end
        trans_ready_i = 1'b0;
        chk("txn_timeout", 32'(cyc < 3000), 1);
        chk("ready_after_last", 32'(req_ready_o), 1);
        chk("busy_after_last", 32'(busy_o), 0);
        if (hold > 0) chk("held_cycles", nstall, hold);
    endtask

    initial begin
        logic [31:0] ea;
        logic [11:0] eb;
        logic [31:0] raddr;

        vecs[0] = '{32'h0000_0100, 16'd4, 1'b1, 0, 1,
                    32'h80, 32'h0, 32'h0, 12'd4, 12'd0, 12'd0, 2'b01};
        vecs[1] = '{32'h0000_03F8, 16'd8, 1'b0, 0, 2,
                    32'h1FC, 32'h200, 32'h0, 12'd4, 12'd4, 12'd0, 2'b01};
        vecs[2] = '{32'h0000_0000, 16'd600, 1'b0, 0, 3,
                    32'h0, 32'h100, 32'h200, 12'd256, 12'd256, 12'd88,
                    2'b01};
        vecs[3] = '{32'h0080_0000, 16'd2, 1'b0, 5, 1,
                    32'h0, 32'h0, 32'h0, 12'd2, 12'd0, 12'd0, 2'b10};
        // Past the device end: wraps to word 0 of the same device.
        vecs[4] = '{32'h007F_FFFC, 16'd4, 1'b1, 0, 2,
                    32'h3F_FFFE, 32'h0, 32'h0, 12'd2, 12'd2, 12'd0, 2'b01};

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(trans_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_addr", trans_address_o, 0);
        chk("rst_cs", 32'(trans_cs_o), 0);
        chk("rst_burst", 32'(trans_burst_o), 0);
        chk("rst_write", 32'(trans_write_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready", 32'(req_ready_o), 1);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            run_req(vecs[v].addr, vecs[v].len, vecs[v].wr, vecs[v].hold, 0);
            chk("vec_count", got_q.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < got_q.size(); i++) begin
                ea = (i == 0) ? vecs[v].a0 : (i == 1) ? vecs[v].a1
                                                      : vecs[v].a2;
                eb = (i == 0) ? vecs[v].b0 : (i == 1) ? vecs[v].b1
                                                      : vecs[v].b2;
                chk("vec_addr", got_q[i].a, ea);
                chk("vec_burst", 32'(got_q[i].b), 32'(eb));
                chk("vec_cs", 32'(got_q[i].cs), 32'(vecs[v].cs));
                chk("vec_write", 32'(got_q[i].w), 32'(vecs[v].wr));
            end
            build_model(vecs[v].addr, int'(vecs[v].len), vecs[v].wr);
            cmp_model("vec_model");
        end

        // Zero-length request.
        req_addr_i  = 32'h0000_0040;
        req_len_i   = 16'd0;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("zero_err", 32'(err_o), 1);
        chk("zero_valid", 32'(trans_valid_o), 0);
        chk("zero_ready", 32'(req_ready_o), 1);
        chk("zero_busy", 32'(busy_o), 0);
        @(posedge clk_i); #1;
        chk("zero_err_drop", 32'(err_o), 0);
        chk("zero_valid2", 32'(trans_valid_o), 0);
        chk("zero_ready2", 32'(req_ready_o), 1);

        // Reset after the first handshake of a long request.
        req_addr_i    = 32'h0;
        req_len_i     = 16'd600;
        req_write_i   = 1'b0;
        req_valid_i   = 1'b1;
        trans_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("mid_valid", 32'(trans_valid_o), 1);
        chk("mid_first_burst", 32'(trans_burst_o), 256);
        @(posedge clk_i); #1;
        chk("mid_second_addr", trans_address_o, 32'h100);
        rst_ni        = 1'b0;
        trans_ready_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mid_rst_valid", 32'(trans_valid_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_burst", 32'(trans_burst_o), 0);
        chk("mid_rst_addr", trans_address_o, 0);
        rst_ni        = 1'b1;
        trans_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("mid_ready_rel", 32'(req_ready_o), 1);
        repeat (3) begin
            chk("mid_no_txn", 32'(trans_valid_o), 0);
            @(posedge clk_i); #1;
        end
        trans_ready_i = 1'b0;
        run_req(32'h0000_0100, 16'd4, 1'b1, 0, 0);
        build_model(32'h0000_0100, 4, 1'b1);
        cmp_model("post_rst");

        // Randomized requests with random back-pressure.
        for (int r = 0; r < 30; r++) begin
            raddr = $urandom;
            if ($urandom_range(0, 3) == 0)
                raddr[22:1] = 22'h3F_FFFF - 22'($urandom_range(0, 600));
            req_len_i = 16'($urandom_range(1, 1200));
            run_req(raddr, req_len_i, 1'($urandom), 0, 30);
            build_model(raddr, int'(req_len_i), req_write_i);
            cmp_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
